// File: rtl/act_collect_pkg.sv
// Shared types and constants for the sigmoid activation path.
// The float_24_8 word and the sigmoid latency live here for both blocks.
package act_collect_pkg;

  typedef logic [31:0] float_24_8;

  // Must track the sigmoid pipeline depth.
  localparam int ACT_COLLECT_DEFAULT_LATENCY = 3;

endpackage

// File: rtl/act_fifo.sv
// Generic DEPTH x 32 show-ahead FIFO with wrap-bit pointers.
// Head word reads as zero while empty.
module act_fifo
  import act_collect_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_clr,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  float_24_8               i_data,
  output float_24_8               o_data,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_level
);

  localparam int AW = $clog2(DEPTH);

  float_24_8   r_mem [DEPTH];
  logic [AW:0] r_wr;
  logic [AW:0] r_rd;

  logic [AW-1:0] w_wa;
  logic [AW-1:0] w_ra;

  assign w_wa = r_wr[AW-1:0];
  assign w_ra = r_rd[AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (i_clr) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_clr) r_mem[w_wa] <= i_data;
  end

  assign o_empty = (r_wr == r_rd);
  assign o_full  = (w_wa == w_ra) && (r_wr[AW] != r_rd[AW]);
  assign o_level = r_wr - r_rd;
  assign o_data  = o_empty ? '0 : r_mem[w_ra];

endmodule

// File: rtl/act_collect.sv
// Re-times sigmoid valid, buffers activations, emits framed stream.
// Optional ACT_COLLECT_STATS_EN adds push/drop counters.
module act_collect
  import act_collect_pkg::*;
#(
  parameter int SIG_LATENCY = ACT_COLLECT_DEFAULT_LATENCY,
  parameter int DEPTH       = 16,
  parameter int FRAME_LEN   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  float_24_8               act_in,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output float_24_8               out_data,
  output logic                    out_last,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow
`ifdef ACT_COLLECT_STATS_EN
  ,
  output logic [31:0]             stat_accepted,
  output logic [31:0]             stat_dropped
`endif
);

  localparam int FW = $clog2(FRAME_LEN) + 1;
  localparam logic [FW-1:0] LAST_IDX = FW'(FRAME_LEN - 1);

  logic [SIG_LATENCY-1:0] r_vdl;
  logic [FW-1:0]          r_frm;
  logic                   r_ovf;

  logic w_vd;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_full;
  logic w_empty;

  // Valid bit travels alongside the sample through sigmoid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vdl <= '0;
    end else if (flush) begin
      r_vdl <= '0;
    end else begin
      r_vdl[0] <= in_valid;
      for (int i = 1; i < SIG_LATENCY; i++) r_vdl[i] <= r_vdl[i-1];
    end
  end

  assign w_vd   = r_vdl[SIG_LATENCY-1];
  assign w_pop  = out_valid & out_ready;
  assign w_push = w_vd & (~w_full | w_pop);
  assign w_drop = w_vd & w_full & ~w_pop;

  act_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_clr   (flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (act_in),
    .o_data  (out_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  assign out_valid = ~w_empty;
  assign out_last  = out_valid & (r_frm == LAST_IDX);
  assign overflow  = r_ovf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frm <= '0;
      r_ovf <= 1'b0;
    end else if (flush) begin
      r_frm <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_pop) r_frm <= out_last ? '0 : r_frm + 1'b1;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

`ifdef ACT_COLLECT_STATS_EN
  logic [31:0] r_acc;
  logic [31:0] r_drp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
      r_drp <= '0;
    end else if (flush) begin
      r_acc <= '0;
      r_drp <= '0;
    end else begin
      if (w_push && r_acc != '1) r_acc <= r_acc + 1'b1;
      if (w_drop && r_drp != '1) r_drp <= r_drp + 1'b1;
    end
  end

  assign stat_accepted = r_acc;
  assign stat_dropped  = r_drp;
`endif

endmodule

// File: tb/tb_act_collect.sv
// Scoreboard bench for act_collect with a sigmoid latency model.
// Stats ports checked when ACT_COLLECT_STATS_EN is defined.
module tb_act_collect;

  localparam int L  = 3;
  localparam int D  = 16;
  localparam int FL = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] sig_in = '0;
  logic [31:0] act_in;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        overflow;
  logic [4:0]  level;
`ifdef ACT_COLLECT_STATS_EN
  logic [31:0] stat_accepted;
  logic [31:0] stat_dropped;
`endif

  logic [31:0] sp [L];
  logic [31:0] exp_q [$];
  int          checks = 0;
  int          failures = 0;
  int          pop_idx = 0;
  int          last_pops = 0;
  logic        s_valid;
  logic        s_last;
  logic [4:0]  s_level;

  always #5 clk = ~clk;

  // Sigmoid stand-in: pure L-cycle data delay.
  always @(posedge clk) begin
    sp[0] <= sig_in;
    for (int i = 1; i < L; i++) sp[i] <= sp[i-1];
  end
  assign act_in = sp[L-1];

  act_collect #(
    .SIG_LATENCY (L),
    .DEPTH       (D),
    .FRAME_LEN   (FL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .act_in    (act_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .level     (level),
    .overflow  (overflow)
`ifdef ACT_COLLECT_STATS_EN
    ,
    .stat_accepted (stat_accepted),
    .stat_dropped  (stat_dropped)
`endif
  );

  // One clock: sample at negedge, score any pop, resume after posedge.
  task automatic tick;
    logic [31:0] e;
    logic        el;
    @(negedge clk);
    s_valid = out_valid;
    s_last  = out_last;
    s_level = level;
    if (!reset || flush) begin
      exp_q.delete();
      pop_idx = 0;
    end else if (out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected got=%h want=none", out_data);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e) begin
          failures++;
          $display("FAIL pop_data got=%h want=%h", out_data, e);
        end
      end
      el = (pop_idx == FL - 1);
      checks++;
      if (out_last !== el) begin
        failures++;
        $display("FAIL pop_last idx=%0d got=%b want=%b", pop_idx, out_last, el);
      end
      if (out_last) last_pops++;
      pop_idx = el ? 0 : pop_idx + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_words(input int n, input logic [31:0] base, input int acc);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      sig_in   = base + 32'(i);
      if (i < acc) exp_q.push_back(base + 32'(i));
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic apply_reset;
    reset = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    last_pops = 0;
  endtask

  task automatic test_reset;
    apply_reset();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b want=0", out_valid); end
    checks++;
    if (out_last !== 1'b0) begin failures++; $display("FAIL rst_last got=%b want=0", out_last); end
    checks++;
    if (level !== 5'd0) begin failures++; $display("FAIL rst_level got=%0d want=0", level); end
    checks++;
    if (out_data !== 32'h0) begin failures++; $display("FAIL rst_data got=%h want=0", out_data); end
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b want=0", overflow); end
  endtask

  task automatic test_latency;
    int rise;
    apply_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    sig_in = 32'h3F000000;
    exp_q.push_back(32'h3F000000);
    rise = -1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (s_valid && rise < 0) rise = k;
      if (k == 0) begin
        sig_in = 32'h3F400000;
        exp_q.push_back(32'h3F400000);
      end else begin
        in_valid = 1'b0;
      end
    end
    checks++;
    if (rise != L + 1) begin failures++; $display("FAIL latency got=%0d want=%0d", rise, L + 1); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL lat_drain got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_frames;
    apply_reset();
    out_ready = 1'b1;
    drive_words(17, 32'h40000000, 17);
    repeat (L + 4) tick();
    checks++;
    if (last_pops != 2) begin failures++; $display("FAIL frame_lasts got=%0d want=2", last_pops); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL frame_drain got=%0d want=0", exp_q.size()); end
    checks++;
    if (s_level !== 5'd0) begin failures++; $display("FAIL frame_level got=%0d want=0", s_level); end
  endtask

  task automatic test_overflow;
    apply_reset();
    drive_words(D + 2, 32'h41000000, D);
    repeat (L + 1) tick();
    checks++;
    if (s_level !== 5'(D)) begin failures++; $display("FAIL ovf_level got=%0d want=%0d", s_level, D); end
    checks++;
    if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b want=1", overflow); end
`ifdef ACT_COLLECT_STATS_EN
    checks++;
    if (stat_accepted !== 32'd16) begin failures++; $display("FAIL stat_acc got=%0d want=16", stat_accepted); end
    checks++;
    if (stat_dropped !== 32'd2) begin failures++; $display("FAIL stat_drp got=%0d want=2", stat_dropped); end
`endif
    out_ready = 1'b1;
    repeat (D + 4) tick();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL ovf_drain got=%0d want=0", exp_q.size()); end
    checks++;
    if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
  endtask

  task automatic test_full_push_pop;
    apply_reset();
    drive_words(D, 32'h42000000, D);
    repeat (L + 1) tick();
    checks++;
    if (s_level !== 5'(D)) begin failures++; $display("FAIL full_fill got=%0d want=%0d", s_level, D); end
    in_valid = 1'b1;
    sig_in = 32'h4200ABCD;
    exp_q.push_back(32'h4200ABCD);
    tick();
    in_valid = 1'b0;
    repeat (L - 1) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    checks++;
    if (s_level !== 5'(D)) begin failures++; $display("FAIL full_pp_level got=%0d want=%0d", s_level, D); end
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL full_pp_ovf got=%b want=0", overflow); end
    out_ready = 1'b1;
    repeat (D + 4) tick();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL full_drain got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_flush;
    int seen;
    apply_reset();
    drive_words(D + 1, 32'h43000000, D);
    repeat (L + 1) tick();
    out_ready = 1'b1;
    repeat (D + 4) tick();
    out_ready = 1'b0;
    drive_words(5, 32'h43100000, 5);
    repeat (L + 1) tick();
    checks++;
    if (s_level !== 5'd5 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL flush_pre level=%0d ovf=%b want=5/1", s_level, overflow);
    end
    drive_words(2, 32'h43200000, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    checks++;
    if (s_level !== 5'd0) begin failures++; $display("FAIL flush_level got=%0d want=0", s_level); end
    checks++;
    if (s_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b want=0", s_valid); end
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL flush_ovf got=%b want=0", overflow); end
    out_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      tick();
      if (s_valid) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL flush_inflight got=%0d want=0", seen); end
  endtask

  task automatic test_async_reset;
    apply_reset();
    drive_words(9, 32'h44000000, 9);
    repeat (L + 1) tick();
    out_ready = 1'b1;
    repeat (FL - 1) tick();
    out_ready = 1'b0;
    tick();
    checks++;
    if (s_last !== 1'b1 || s_valid !== 1'b1) begin
      failures++;
      $display("FAIL arst_pre last=%b valid=%b want=1/1", s_last, s_valid);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b want=0", out_valid); end
    checks++;
    if (level !== 5'd0) begin failures++; $display("FAIL arst_level got=%0d want=0", level); end
    checks++;
    if (out_last !== 1'b0) begin failures++; $display("FAIL arst_last got=%b want=0", out_last); end
    tick();
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    drive_words(2, 32'h44100000, 2);
    repeat (L + 4) tick();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL arst_resume got=%0d want=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_frames();
    test_overflow();
    test_full_push_pop();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
